// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner for the combination lock.
// Synchronises and debounces rows; one newKey pulse per accepted press.
module keypad_scan #(
    parameter int SCAN_DIV  = 16,
    parameter int DEB_COUNT = 4
) (
    input  logic       clk5,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       newKey,
    output logic [4:0] keyCode,
    output logic       keyDown
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_COUNT + 1);
    localparam logic [TW-1:0] TMAX    = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_COUNT);

    typedef enum logic [1:0] {SCAN, DEB, PRESS, HOLD} state_t;

    state_t        state_q, state_d;
    logic [3:0]    rows_m_q, rows_s_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    cand_q, cand_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [DW-1:0] rel_q, rel_d;
    logic [4:0]    key_code_q, key_code_d;

    logic          sample;
    logic          hit;
    logic [1:0]    hit_row;
    logic [DW-1:0] deb_inc, rel_inc;

    function automatic logic [3:0] key_hex(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] h;
        h = 4'h0;
        case ({r, c})
            4'd0:  h = 4'h1;
            4'd1:  h = 4'h2;
            4'd2:  h = 4'h3;
            4'd3:  h = 4'hA;
            4'd4:  h = 4'h4;
            4'd5:  h = 4'h5;
            4'd6:  h = 4'h6;
            4'd7:  h = 4'hB;
            4'd8:  h = 4'h7;
            4'd9:  h = 4'h8;
            4'd10: h = 4'h9;
            4'd11: h = 4'hC;
            4'd12: h = 4'hE;
            4'd13: h = 4'h0;
            4'd14: h = 4'hF;
            default: h = 4'hD;
        endcase
        return h;
    endfunction

    always_ff @(posedge clk5) begin
        if (!reset) begin
            state_q    <= SCAN;
            rows_m_q   <= 4'b1111;
            rows_s_q   <= 4'b1111;
            timer_q    <= '0;
            col_q      <= 2'd0;
            cand_q     <= 2'd0;
            deb_q      <= '0;
            rel_q      <= '0;
            key_code_q <= 5'b00000;
        end else begin
            state_q    <= state_d;
            rows_m_q   <= rows;
            rows_s_q   <= rows_m_q;
            timer_q    <= timer_d;
            col_q      <= col_d;
            cand_q     <= cand_d;
            deb_q      <= deb_d;
            rel_q      <= rel_d;
            key_code_q <= key_code_d;
        end
    end

    always_comb begin
        sample  = (timer_q == TMAX);
        hit     = 1'b0;
        hit_row = 2'd0;
        case (rows_s_q)
            4'b1110: begin hit = 1'b1; hit_row = 2'd0; end
            4'b1101: begin hit = 1'b1; hit_row = 2'd1; end
            4'b1011: begin hit = 1'b1; hit_row = 2'd2; end
            4'b0111: begin hit = 1'b1; hit_row = 2'd3; end
            default: begin hit = 1'b0; hit_row = 2'd0; end
        endcase
        deb_inc = (deb_q == DEB_MAX) ? deb_q : deb_q + 1'b1;
        rel_inc = (rel_q == DEB_MAX) ? rel_q : rel_q + 1'b1;
    end

    always_comb begin
        timer_d    = sample ? '0 : timer_q + 1'b1;
        state_d    = state_q;
        col_d      = col_q;
        cand_d     = cand_q;
        deb_d      = deb_q;
        rel_d      = rel_q;
        key_code_d = key_code_q;
        unique case (state_q)
            SCAN: begin
                if (sample) begin
                    if (hit) begin
                        cand_d  = hit_row;
                        deb_d   = DW'(1);
                        state_d = DEB;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            DEB: begin
                if (sample) begin
                    if (hit && hit_row == cand_q) begin
                        deb_d = deb_inc;
                        if (deb_inc == DEB_MAX) begin
                            state_d    = PRESS;
                            key_code_d = {1'b1, key_hex(cand_q, col_q)};
                        end
                    end else begin
                        state_d = SCAN;
                        deb_d   = '0;
                        col_d   = col_q + 2'd1;
                    end
                end
            end
            PRESS: begin
                state_d = HOLD;
                deb_d   = '0;
                rel_d   = '0;
            end
            HOLD: begin
                // Release is judged on the frozen column only
                if (sample) begin
                    if (rows_s_q == 4'b1111) begin
                        rel_d = rel_inc;
                        if (rel_inc == DEB_MAX) begin
                            state_d = SCAN;
                            rel_d   = '0;
                            col_d   = col_q + 2'd1;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign cols    = ~(4'b0001 << col_q);
    assign newKey  = (state_q == PRESS);
    assign keyDown = (state_q == PRESS) || (state_q == HOLD);
    assign keyCode = key_code_q;

endmodule
